// File: rtl/cam_frame_writer_if.sv
// Camera byte bus in, frame-buffer BRAM write port out.
// master = the frame writer; slave = camera source / BRAM side.
interface cam_frame_writer_if #(
  parameter int ADDR_W = 17
);
  logic              cam_vsync;
  logic              cam_href;
  logic [7:0]        cam_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;

  modport master (
    input  cam_vsync, cam_href, cam_data,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    output cam_vsync, cam_href, cam_data,
    input  wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/cam_frame_writer.sv
// RGB444 camera capture into a raster-order frame buffer, optional 2:1 decimation.
// Write strobe 2 pclk after the second pixel byte is on the pins; no backpressure.
module cam_frame_writer #(
  parameter int IN_WIDTH   = 640,
  parameter int IN_HEIGHT  = 480,
  parameter int DECIMATE   = 1,
  parameter int OUT_WIDTH  = IN_WIDTH >> DECIMATE,
  parameter int OUT_HEIGHT = IN_HEIGHT >> DECIMATE,
  parameter int ADDR_W     = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 capture_en,
  cam_frame_writer_if.master   bus,
  output logic                 frame_done,
  output logic                 line_err,
  output logic [7:0]           frame_count
);

  localparam int XW        = $clog2(IN_WIDTH + 2);
  localparam int YW        = $clog2(IN_HEIGHT + 2);
  localparam int OUT_TOTAL = OUT_WIDTH * OUT_HEIGHT;

  localparam logic [XW-1:0]     X_END     = XW'(IN_WIDTH);
  localparam logic [XW-1:0]     X_MAX     = XW'(IN_WIDTH + 1);
  localparam logic [YW-1:0]     Y_END     = YW'(IN_HEIGHT);
  localparam logic [YW-1:0]     Y_MAX     = YW'(IN_HEIGHT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              s_vsync_q, s_href_q;
  logic [7:0]        s_data_q;
  logic              p_vsync_q, p_href_q;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              phase_q, phase_d;
  logic [3:0]        r_q, r_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [11:0]       wr_data_q, wr_data_d;
  logic              full_q, full_d;
  logic              frame_done_q, frame_done_d;
  logic              line_err_q, line_err_d;
  logic [7:0]        frame_count_q, frame_count_d;

  logic vs_fall, vs_rise, href_fall, keep;

  assign vs_fall   = p_vsync_q & ~s_vsync_q;
  assign vs_rise   = ~p_vsync_q & s_vsync_q;
  assign href_fall = p_href_q & ~s_href_q;
  assign keep      = (DECIMATE == 0) || (!x_q[0] && !y_q[0]);

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    phase_d       = phase_q;
    r_d           = r_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    full_d        = full_q;
    frame_done_d  = 1'b0;
    line_err_d    = line_err_q;
    frame_count_d = frame_count_q;

    // Address advances after each write; the last slot latches full instead.
    if (wr_en_q) begin
      if (wr_addr_q == LAST_ADDR) full_d = 1'b1;
      else                        wr_addr_d = wr_addr_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (capture_en) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (vs_fall) begin
          state_d    = ACTIVE;
          x_d        = '0;
          y_d        = '0;
          phase_d    = 1'b0;
          wr_addr_d  = '0;
          full_d     = 1'b0;
          line_err_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
          if (y_q != Y_END) line_err_d = 1'b1;
          state_d = capture_en ? WAIT_VS : IDLE;
        end else if (s_href_q) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            r_d = s_data_q[3:0];
          end else begin
            if (x_q != X_MAX) x_d = x_q + 1'b1;
            if (x_q >= X_END) begin
              line_err_d = 1'b1;
            end else if (keep) begin
              if (full_q) begin
                line_err_d = 1'b1;
              end else begin
                wr_en_d   = 1'b1;
                wr_data_d = {r_q, s_data_q};
              end
            end
          end
        end else if (href_fall) begin
          if ((x_q != X_END) || phase_q) line_err_d = 1'b1;
          if (y_q != Y_MAX) y_d = y_q + 1'b1;
          x_d     = '0;
          phase_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      s_vsync_q     <= 1'b0;
      s_href_q      <= 1'b0;
      s_data_q      <= '0;
      p_vsync_q     <= 1'b0;
      p_href_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      phase_q       <= 1'b0;
      r_q           <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      full_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      s_vsync_q     <= bus.cam_vsync;
      s_href_q      <= bus.cam_href;
      s_data_q      <= bus.cam_data;
      p_vsync_q     <= s_vsync_q;
      p_href_q      <= s_href_q;
      x_q           <= x_d;
      y_q           <= y_d;
      phase_q       <= phase_d;
      r_q           <= r_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      full_q        <= full_d;
      frame_done_q  <= frame_done_d;
      line_err_q    <= line_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign frame_done   = frame_done_q;
  assign line_err     = line_err_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Bench for cam_frame_writer: a decimating 16x8 instance (a) and a full-rate 8x4 instance (b)
// share one camera bus; a queue-based frame model predicts every BRAM write.
module tb_cam_frame_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cap_a, cap_b;
  logic       vs, hr;
  logic [7:0] dat;

  logic       fd_a, le_a, fd_b, le_b;
  logic [7:0] fc_a, fc_b;

  int checks = 0;
  int errors = 0;
  int wr_cnt_a = 0, wr_cnt_b = 0, done_a = 0, done_b = 0;
  logic err_done_a = 1'b0, err_done_b = 1'b0;

  logic [28:0] qa[$];
  logic [28:0] qb[$];
  logic [28:0] exp_a, exp_b;

  always #5 clk = ~clk;

  cam_frame_writer_if #(.ADDR_W(17)) if_a ();
  cam_frame_writer_if #(.ADDR_W(17)) if_b ();

  assign if_a.cam_vsync = vs;
  assign if_a.cam_href  = hr;
  assign if_a.cam_data  = dat;
  assign if_b.cam_vsync = vs;
  assign if_b.cam_href  = hr;
  assign if_b.cam_data  = dat;

  cam_frame_writer #(.IN_WIDTH(16), .IN_HEIGHT(8), .DECIMATE(1), .ADDR_W(17)) dut_a (
    .clk(clk), .rst_n(rst_n), .capture_en(cap_a), .bus(if_a.master),
    .frame_done(fd_a), .line_err(le_a), .frame_count(fc_a)
  );

  cam_frame_writer #(.IN_WIDTH(8), .IN_HEIGHT(4), .DECIMATE(0), .ADDR_W(17)) dut_b (
    .clk(clk), .rst_n(rst_n), .capture_en(cap_b), .bus(if_b.master),
    .frame_done(fd_b), .line_err(le_b), .frame_count(fc_b)
  );

  function automatic int in_w(input int d);
    return (d == 0) ? 16 : 8;
  endfunction
  function automatic int in_h(input int d);
    return (d == 0) ? 8 : 4;
  endfunction
  function automatic int dec(input int d);
    return (d == 0) ? 1 : 0;
  endfunction
  function automatic int out_total(input int d);
    return (in_w(d) >> dec(d)) * (in_h(d) >> dec(d));
  endfunction
  function automatic logic le_of(input int d);
    return (d == 0) ? le_a : le_b;
  endfunction

  // Write monitors: every strobe must match the oldest predicted write.
  always @(negedge clk) begin
    if (if_a.wr_en === 1'b1) begin
      wr_cnt_a++;
      if (qa.size() != 0) exp_a = qa.pop_front();
      else                exp_a = 'x;
      checks++;
      assert ({if_a.wr_addr, if_a.wr_data} === exp_a) else begin
        errors++;
        $error("FAIL write_a: observed addr/data %h expected %h", {if_a.wr_addr, if_a.wr_data}, exp_a);
      end
    end
    if (fd_a === 1'b1) begin
      done_a++;
      err_done_a = le_a;
    end
  end

  always @(negedge clk) begin
    if (if_b.wr_en === 1'b1) begin
      wr_cnt_b++;
      if (qb.size() != 0) exp_b = qb.pop_front();
      else                exp_b = 'x;
      checks++;
      assert ({if_b.wr_addr, if_b.wr_data} === exp_b) else begin
        errors++;
        $error("FAIL write_b: observed addr/data %h expected %h", {if_b.wr_addr, if_b.wr_data}, exp_b);
      end
    end
    if (fd_b === 1'b1) begin
      done_b++;
      err_done_b = le_b;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic h, input logic [7:0] d);
    @(negedge clk);
    vs  = v;
    hr  = h;
    dat = d;
  endtask

  task automatic set_cap(input int d, input logic v);
    if (d == 0) cap_a = v;
    else        cap_b = v;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One camera frame; the model predicts writes as stored-pixel ordinal -> address.
  task automatic run_frame(input int d, input int nlines, input int short_y, input int short_n,
                           input int en_y, input int drop_y, input int rst_y,
                           input bit modeled, input bit fixed, output bit exp_err);
    int         n_keep;
    int         n;
    bit         mdl;
    logic [7:0] b0, b1;
    mdl     = modeled;
    exp_err = 1'b0;
    n_keep  = 0;
    repeat (4) cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    repeat (3) cyc(1'b0, 1'b0, 8'($urandom));
    for (int y = 0; y < nlines; y++) begin
      if (y == en_y)   set_cap(d, 1'b1);
      if (y == drop_y) set_cap(d, 1'b0);
      if (y == rst_y) begin
        pulse_reset();
        mdl = 1'b0;
      end
      n = (y == short_y) ? short_n : in_w(d);
      if (n != in_w(d)) exp_err = 1'b1;
      for (int x = 0; x < n; x++) begin
        b0 = fixed ? 8'h0A : 8'($urandom);
        b1 = fixed ? 8'h5C : 8'($urandom);
        cyc(1'b0, 1'b1, b0);
        cyc(1'b0, 1'b1, b1);
        if (x >= in_w(d)) begin
          exp_err = 1'b1;
        end else if (dec(d) == 0 || (x % 2 == 0 && y % 2 == 0)) begin
          if (n_keep < out_total(d)) begin
            if (d == 0 && mdl) qa.push_back({17'(n_keep), b0[3:0], b1});
            if (d == 1 && mdl) qb.push_back({17'(n_keep), b0[3:0], b1});
          end else begin
            exp_err = 1'b1;
          end
          n_keep++;
        end
      end
      repeat (4) cyc(1'b0, 1'b0, 8'($urandom));
      if (y == short_y && mdl) chk("line_err_after_short_line", 32'(le_of(d)), 32'd1);
    end
    if (nlines != in_h(d)) exp_err = 1'b1;
    repeat (7) cyc(1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    bit e;
    int w0, d0;
    rst_n = 1'b0;
    cap_a = 1'b0;
    cap_b = 1'b0;
    vs    = 1'b1;
    hr    = 1'b0;
    dat   = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vs  = 1'($urandom);
      hr  = 1'($urandom);
      dat = 8'($urandom);
    end
    chk("reset_wr_en",       32'(if_a.wr_en),   32'd0);
    chk("reset_wr_addr",     32'(if_a.wr_addr), 32'd0);
    chk("reset_frame_done",  32'(fd_a),         32'd0);
    chk("reset_line_err",    32'(le_a),         32'd0);
    chk("reset_frame_count", 32'(fc_a),         32'd0);
    chk("reset_frame_count_b", 32'(fc_b),       32'd0);
    @(negedge clk);
    vs    = 1'b1;
    hr    = 1'b0;
    rst_n = 1'b1;

    // Full-rate 8x4 buffer fed five lines: overflow after 32 writes.
    cap_b = 1'b1;
    w0 = wr_cnt_b;
    run_frame(1, 5, -1, 0, -1, 4, -1, 1'b1, 1'b0, e);
    chk("ovf_writes",      32'(wr_cnt_b - w0), 32'd32);
    chk("ovf_queue_empty", 32'(qb.size()),     32'd0);
    chk("ovf_addr_hold",   32'(if_b.wr_addr),  32'd31);
    chk("ovf_line_err",    32'(le_b),          32'(e));
    chk("ovf_frame_done",  32'(done_b),        32'd1);
    chk("ovf_frame_count", 32'(fc_b),          32'd1);

    // Clean decimated frame with the fixed 0A/5C pattern.
    cap_a = 1'b1;
    w0 = wr_cnt_a;
    run_frame(0, 8, -1, 0, -1, -1, -1, 1'b1, 1'b1, e);
    chk("full_writes",      32'(wr_cnt_a - w0), 32'd32);
    chk("full_queue_empty", 32'(qa.size()),     32'd0);
    chk("full_last_addr",   32'(if_a.wr_addr),  32'd31);
    chk("full_line_err",    32'(le_a),          32'(e));
    chk("full_frame_done",  32'(done_a),        32'd1);
    chk("full_frame_count", 32'(fc_a),          32'd1);

    // Short even line: one pixel fewer stored.
    w0 = wr_cnt_a;
    run_frame(0, 8, 2, 14, -1, -1, -1, 1'b1, 1'b0, e);
    chk("short_writes",      32'(wr_cnt_a - w0), 32'd31);
    chk("short_queue_empty", 32'(qa.size()),     32'd0);
    chk("short_line_err",    32'(le_a),          32'(e));
    chk("short_frame_count", 32'(fc_a),          32'd2);

    // Missing last line: error must already be up when frame_done pulses.
    w0 = wr_cnt_a;
    run_frame(0, 7, -1, 0, -1, -1, -1, 1'b1, 1'b0, e);
    chk("lines_writes",      32'(wr_cnt_a - w0), 32'd32);
    chk("lines_err_at_done", 32'(err_done_a),    32'(e));
    chk("lines_frame_count", 32'(fc_a),          32'd3);

    // Enable dropped mid-frame: frame completes, following frame ignored.
    w0 = wr_cnt_a;
    run_frame(0, 8, -1, 0, -1, 3, -1, 1'b1, 1'b0, e);
    chk("drop_writes",      32'(wr_cnt_a - w0), 32'd32);
    chk("drop_line_err",    32'(le_a),          32'(e));
    chk("drop_frame_count", 32'(fc_a),          32'd4);
    w0 = wr_cnt_a;
    d0 = done_a;
    run_frame(0, 8, -1, 0, -1, -1, -1, 1'b0, 1'b0, e);
    chk("idle_writes",      32'(wr_cnt_a - w0), 32'd0);
    chk("idle_frame_done",  32'(done_a - d0),   32'd0);
    chk("idle_frame_count", 32'(fc_a),          32'd4);

    // Enable mid-frame, then reset in the middle of the next captured frame.
    w0 = wr_cnt_a;
    run_frame(0, 8, -1, 0, 2, -1, -1, 1'b0, 1'b0, e);
    chk("late_en_writes", 32'(wr_cnt_a - w0), 32'd0);
    w0 = wr_cnt_a;
    d0 = done_a;
    run_frame(0, 8, -1, 0, -1, -1, 3, 1'b1, 1'b0, e);
    chk("rst_writes",      32'(wr_cnt_a - w0), 32'd16);
    chk("rst_queue_empty", 32'(qa.size()),     32'd0);
    chk("rst_frame_done",  32'(done_a - d0),   32'd0);
    chk("rst_frame_count", 32'(fc_a),          32'd0);
    chk("rst_line_err",    32'(le_a),          32'd0);
    w0 = wr_cnt_a;
    run_frame(0, 8, -1, 0, -1, -1, -1, 1'b1, 1'b0, e);
    chk("post_rst_writes",      32'(wr_cnt_a - w0), 32'd32);
    chk("post_rst_queue_empty", 32'(qa.size()),     32'd0);
    chk("post_rst_line_err",    32'(le_a),          32'(e));
    chk("post_rst_frame_count", 32'(fc_a),          32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
